// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared constants, types and helpers for the RAM arbiter
//
// Holds the RAM word width, requester count, the opcode nibbles understood
// by the data RAM, the arbiter state encoding and small helper functions.
// Imported by every file of the arbiter slice.

package ram_arbiter_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int N_REQ      = 3;
    localparam int ADDR_WIDTH = 8;

    // Opcode nibbles: top nibble selects the unit, next nibble the operation.
    localparam logic [3:0] RAM_OP    = 4'h9;
    localparam logic [3:0] PC_OP     = 4'h7;
    localparam logic [3:0] RAM_WRITE = 4'h1;
    localparam logic [3:0] RAM_READ  = 4'h2;

    // Port 2 is the program counter; it can only read.
    localparam logic [1:0] PORT_PC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    // Next port in cyclic order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [N_REQ-1:0] port_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Opcode presented to the RAM for the current transaction.
    function automatic logic [DATA_WIDTH-1:0] access_opcode(input logic we,
                                                            input logic [1:0] idx);
        if (we)
            return {RAM_OP, RAM_WRITE, 8'h00};
        else if (idx == PORT_PC)
            return {PC_OP, 12'h000};
        else
            return {RAM_OP, RAM_READ, 8'h00};
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester-side handshake bundle of the RAM arbiter
//
// Signals:
//   req, req_we           per-port request and write flag (req_we[2] ignored)
//   req_addr, req_wdata   packed per-port address (8b each) and write data (16b each)
//   gnt, rsp_valid        one-hot single-cycle grant / completion pulses
//   rsp_data              read data, valid with rsp_valid (0 after writes)
//   busy                  arbiter in ACCESS or DONE
// Modports: master = requesters, slave = arbiter.

interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_data;
    logic                        busy;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/ram_arbiter_rr_pick3.sv
// rtl/ram_arbiter_rr_pick3.sv - round-robin winner select among three requesters
//
// Ports:
//   req_i    request vector
//   ptr_i    highest-priority port; priority descends cyclically from it
//   valid_o  any request present
//   idx_o    winning port index (0 when valid_o is low)

module rr_pick3
    import ram_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic             valid_o,
    output logic [1:0]       idx_o
);

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    always_comb begin
        // An out-of-range pointer is treated as port 0.
        cand0   = (ptr_i > 2'd2) ? 2'd0 : ptr_i;
        cand1   = next_port(cand0);
        cand2   = next_port(cand1);
        valid_o = |req_i;
        idx_o   = 2'd0;
        // Lowest priority first so the highest-priority hit is assigned last.
        if (req_i[cand2]) idx_o = cand2;
        if (req_i[cand1]) idx_o = cand1;
        if (req_i[cand0]) idx_o = cand0;
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port data RAM arbiter for ROM loader, ALU and PC ports
//
// One RAM transaction at a time through IDLE -> ACCESS -> DONE. A request
// seen in IDLE is captured, granted in ACCESS (RAM enables driven) and
// answered in DONE. RAM outputs decode from registered state only.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   bus                   requester handshake (ram_arbiter_if.slave)
//   ram_opcode_o          RAM opcode (0x9200 read, 0x9100 write, 0x7000 PC read)
//   ram_operand_o         {8'h00, addr}
//   ram_write_data_o      write data
//   ram_read_enable_o     read strobe
//   ram_write_enable_o    write strobe, gated off while reset_i is high
//   ram_read_data_i       combinational read data from the RAM
//
// Build option: define RAM_ARB_FIXED_PRI_EN for fixed priority 0 > 1 > 2
// (no round-robin pointer); default is round-robin.

module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    ram_arbiter_if.slave          bus,
    output logic [DATA_WIDTH-1:0] ram_opcode_o,
    output logic [DATA_WIDTH-1:0] ram_operand_o,
    output logic [DATA_WIDTH-1:0] ram_write_data_o,
    output logic                  ram_read_enable_o,
    output logic                  ram_write_enable_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data_i
);

    arb_state_e            state_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            idx_q;
    logic [N_REQ-1:0]      gnt_q;
    logic [N_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  busy_q;

    logic                  pick_valid;
    logic [1:0]            pick_idx;

`ifdef RAM_ARB_FIXED_PRI_EN
    always_comb begin
        pick_valid = |bus.req;
        if (bus.req[0])
            pick_idx = 2'd0;
        else if (bus.req[1])
            pick_idx = 2'd1;
        else
            pick_idx = 2'd2;
    end
`else
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    assign ptr_d = next_port(pick_idx);

    // Pointer advances only when a grant is actually issued.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            ptr_q <= 2'd0;
        else if (state_q == ST_IDLE && pick_valid)
            ptr_q <= ptr_d;
    end

    rr_pick3 u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            idx_q       <= 2'd0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        // The PC port is forced to read whatever req_we says.
                        we_q    <= bus.req_we[pick_idx] & (pick_idx != PORT_PC);
                        addr_q  <= bus.req_addr[{pick_idx, 3'b000} +: ADDR_WIDTH];
                        wdata_q <= bus.req_wdata[{pick_idx, 4'b0000} +: DATA_WIDTH];
                        idx_q   <= pick_idx;
                        gnt_q   <= port_onehot(pick_idx);
                        busy_q  <= 1'b1;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rsp_data_q  <= we_q ? '0 : ram_read_data_i;
                    rsp_valid_q <= port_onehot(idx_q);
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM side: quiet outside ACCESS. The write strobe is masked by reset so
    // an aborted write never lands on the reset edge.
    always_comb begin
        ram_opcode_o       = '0;
        ram_operand_o      = '0;
        ram_write_data_o   = '0;
        ram_read_enable_o  = 1'b0;
        ram_write_enable_o = 1'b0;
        if (state_q == ST_ACCESS) begin
            ram_opcode_o  = access_opcode(we_q, idx_q);
            ram_operand_o = {8'h00, addr_q};
            if (we_q) begin
                ram_write_data_o   = wdata_q;
                ram_write_enable_o = ~reset_i;
            end else begin
                ram_read_enable_o  = 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates single-port access to the 256 x 16 data RAM between three requesters: ROM loader (port 0), register/ALU unit (port 1) and program counter (port 2). It issues one RAM transaction at a time through a three-state sequencer, generating the opcode, operand, write-data and enable signals the RAM expects. Requesters see a simple req/gnt/response handshake and never drive the RAM directly.

## Interface
- `DATA_WIDTH`, 16: RAM word width, shared define.
- `N_REQ`, 3: requester count; fixed at 3.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 3: per-requester access request, one bit per port.
- `req_we` in 3: 1 = write, 0 = read. Bit 2 is ignored because the PC port is read-only.
- `req_addr` in 24: three 8-bit addresses; port i uses bits [8i+7:8i].
- `req_wdata` in 48: write data for ports 0 and 1; port i uses bits [16i+15:16i]. Bits [47:32] are unused.
- `gnt` out 3: one-hot, one-cycle pulse; indicates the request was accepted.
- `rsp_valid` out 3: one-hot, one-cycle pulse; indicates the transaction completed.
- `rsp_data` out 16: read data, valid while `rsp_valid` is high. Holds 0 after writes.
- `busy` out 1: high in ACCESS and DONE.
- `ram_opcode` out 16: opcode to the RAM.
- `ram_operand` out 16: `{8'h00, addr}` to the RAM.
- `ram_write_data` out 16: write data to the RAM.
- `ram_read_enable` out 1: RAM read enable.
- `ram_write_enable` out 1: RAM write enable.
- `ram_read_data` in 16: RAM read data; combinational from the RAM.

## Operation
- **States**
  - IDLE: no access in progress.
  - ACCESS: RAM enables driven for one cycle.
  - DONE: response cycle. Returns to IDLE unconditionally.
- **IDLE**
  - If `req` is nonzero, select a winner and register its `we`, address, write data and index.
  - Pulse the winner's `gnt` bit in the following cycle and move to ACCESS.
- **Handshake rules**
  - A requester holds `req`, `req_we`, `req_addr` and `req_wdata` stable until it sees `gnt`. After `gnt` it may drop or change them.
  - A request withdrawn before `gnt` is dropped silently.
- **ACCESS, read**
  - Drive `ram_opcode` = 0x9200 for ports 0/1, or 0x7000 for port 2.
  - `ram_read_enable` = 1.
  - Capture `ram_read_data` into the `rsp_data` register at the closing edge.
- **ACCESS, write** (ports 0/1 only)
  - `ram_opcode` = 0x9100, `ram_write_data` = registered data, `ram_write_enable` = 1.
  - The RAM commits the write at the closing edge.
- **DONE**
  - Pulse `rsp_valid[winner]`.
  - `rsp_data` holds the read value for reads and 0 for writes.
- **Outside ACCESS**: all `ram_*` outputs are 0 and both enables are low.
- **Round-robin selection**
  - The pointer names the highest-priority port; priority then descends cyclically.
  - After each grant the pointer becomes winner+1 mod 3.
  - Pointer resets to 0.
- **Reset**
  - All outputs reset to 0, state resets to IDLE, captured fields reset to 0.
  - Reset asserted during ACCESS aborts the transaction. `ram_write_enable` is gated with `~reset` so no write commits on the reset edge, and no `gnt` or `rsp_valid` follows.

## Timing
- Request seen at edge T: `gnt` high in cycle T+1 (ACCESS), `rsp_valid` high in cycle T+2 (DONE), back in IDLE at T+3.
- Minimum request-to-response latency is 2 cycles. Peak throughput is one transaction per 3 cycles.
- Requests arriving during ACCESS or DONE wait for IDLE.
- `gnt`, `rsp_valid`, `rsp_data` and `busy` are registered.
- `ram_*` outputs are decoded from registered state only; there is no combinational path from `req` to the RAM.

## Configuration
- `RAM_ARB_FIXED_PRI_EN`
  - Defined: fixed priority, port 0 > port 1 > port 2. The pointer is not implemented.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Shared defines header holds `DATA_WIDTH`, the `RAM_OP`/`ROM_OP`/`REG_OP`/`PC_OP` nibbles and the `RAM_WRITE`/`RAM_READ` codes. These are reused by the RAM and the arbiter.
- State encodings are local parameters.
- One sub-module, `rr_pick3`: combinational winner select from `req` and the pointer. Under `RAM_ARB_FIXED_PRI_EN` it is bypassed by a priority encoder.

## Test plan
- **Port 1 write, then port 0 read**
  - Stimulus: port 1 writes 0xBEEF to addr 0x10; port 0 then reads 0x10.
  - Required response: `gnt[1]` at T+1, `rsp_valid[1]` at T+2; the read returns `rsp_data` = 0xBEEF with `rsp_valid[0]`.
- **All three requesting continuously from reset**
  - Round-robin build: grants follow 0, 1, 2, 0, 1, 2, each 3 cycles apart.
  - `RAM_ARB_FIXED_PRI_EN` build: only port 0 is granted.
- **PC port read-only**
  - Stimulus: port 2 with `req_we[2]` = 1 targeting addr 0x20, which holds 0x1234.
  - Required response: a read with opcode 0x7000; `rsp_data` = 0x1234 and the RAM contents are unchanged.
- **Withdrawn request**
  - Stimulus: port 0 raises `req` for 1 cycle while the arbiter is in ACCESS, then drops it.
  - Required response: no `gnt[0]`, no RAM access.
- **Reset during a write**
  - Stimulus: reset pulsed in the ACCESS cycle of a write of 0x5555 to addr 0x30, which holds 0x0000.
  - Required response: addr 0x30 still reads 0x0000; all outputs are 0 the next cycle.
